id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_MemtoReg,
  input  logic        ID_ALUSrc,
  input  logic        ID_RegDst,
  input  logic [3:0]  ID_ALUOp,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_SignExt,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_valid,
  input  logic        flush,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_RegDst,
  output logic [3:0]  ID_EX_ALUOp,
  output logic [31:0] ID_EX_ReadData1,
  output logic [31:0] ID_EX_ReadData2,
  output logic [31:0] ID_EX_SignExt,
  output logic [4:0]  ID_EX_Rs,
  output logic [4:0]  ID_EX_Rt,
  output logic [4:0]  ID_EX_Rd,
  output logic        ID_EX_valid,
  output logic        stall,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic [15:0] bubble_count
);

  logic rs_hit;
  logic rt_hit;
  logic bubble;

  always_comb begin
    rs_hit = ID_UsesRs && (ID_Rs == ID_EX_Rt);
    rt_hit = ID_UsesRt && (ID_Rt == ID_EX_Rt);
    // A taken branch in EX kills the ID instruction, so its hazard is moot.
    stall  = ID_valid && ID_EX_valid && ID_EX_MemRead && (ID_EX_Rt != 5'd0)
             && (rs_hit || rt_hit) && !flush;
    PCWrite     = !stall;
    IF_ID_Write = !stall;
    bubble      = stall || flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_RegWrite  <= 1'b0;
      ID_EX_MemRead   <= 1'b0;
      ID_EX_MemWrite  <= 1'b0;
      ID_EX_MemtoReg  <= 1'b0;
      ID_EX_ALUSrc    <= 1'b0;
      ID_EX_RegDst    <= 1'b0;
      ID_EX_ALUOp     <= 4'd0;
      ID_EX_valid     <= 1'b0;
      ID_EX_ReadData1 <= 32'd0;
      ID_EX_ReadData2 <= 32'd0;
      ID_EX_SignExt   <= 32'd0;
      ID_EX_Rs        <= 5'd0;
      ID_EX_Rt        <= 5'd0;
      ID_EX_Rd        <= 5'd0;
      bubble_count    <= 16'd0;
    end else begin
      // Data and specifiers always load; only control is zeroed for a bubble.
      ID_EX_ReadData1 <= ID_ReadData1;
      ID_EX_ReadData2 <= ID_ReadData2;
      ID_EX_SignExt   <= ID_SignExt;
      ID_EX_Rs        <= ID_Rs;
      ID_EX_Rt        <= ID_Rt;
      ID_EX_Rd        <= ID_Rd;
      if (bubble) begin
        ID_EX_RegWrite <= 1'b0;
        ID_EX_MemRead  <= 1'b0;
        ID_EX_MemWrite <= 1'b0;
        ID_EX_MemtoReg <= 1'b0;
        ID_EX_ALUSrc   <= 1'b0;
        ID_EX_RegDst   <= 1'b0;
        ID_EX_ALUOp    <= 4'd0;
        ID_EX_valid    <= 1'b0;
      end else begin
        ID_EX_RegWrite <= ID_RegWrite;
        ID_EX_MemRead  <= ID_MemRead;
        ID_EX_MemWrite <= ID_MemWrite;
        ID_EX_MemtoReg <= ID_MemtoReg;
        ID_EX_ALUSrc   <= ID_ALUSrc;
        ID_EX_RegDst   <= ID_RegDst;
        ID_EX_ALUOp    <= ID_ALUOp;
        ID_EX_valid    <= ID_valid;
      end
      if (stall && (bubble_count != 16'hFFFF)) begin
        bubble_count <= bubble_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_UsesRs, ID_UsesRt, ID_valid, flush;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic        ID_EX_ALUSrc, ID_EX_RegDst;
  logic [3:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExt;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic        ID_EX_valid, stall, PCWrite, IF_ID_Write;
  logic [15:0] bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExt(ID_SignExt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_valid(ID_valid), .flush(flush),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_RegDst(ID_EX_RegDst), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_SignExt(ID_EX_SignExt), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_valid(ID_EX_valid), .stall(stall), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .bubble_count(bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load word: rt <- mem[rs + imm]
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst} = 6'b110110;
    ID_ALUOp = 4'h2;
    ID_Rs = rs; ID_Rt = rt; ID_Rd = 5'd0;
    ID_UsesRs = 1'b1; ID_UsesRt = 1'b0; ID_valid = 1'b1;
    ID_ReadData1 = 32'hA000_0000 | 32'(rs);
    ID_ReadData2 = 32'hB000_0000 | 32'(rt);
    ID_SignExt = 32'h0000_0010;
  endtask

  // R-type add: rd <- rs + rt
  task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic v);
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst} = 6'b100001;
    ID_ALUOp = 4'h5;
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_UsesRs = urs; ID_UsesRt = urt; ID_valid = v;
    ID_ReadData1 = 32'hC000_0000 | 32'(rs);
    ID_ReadData2 = 32'hD000_0000 | 32'(rt);
    ID_SignExt = 32'hFFFF_FFF0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    set_lw(5'd5, 5'd5);
    #2;
    check("rst_valid", 32'(ID_EX_valid), 32'd0);
    check("rst_memread", 32'(ID_EX_MemRead), 32'd0);
    check("rst_rt", 32'(ID_EX_Rt), 32'd0);
    check("rst_bubbles", 32'(bubble_count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd1);
    tick();
    rst_n = 1'b1;

    // lw $5 into EX
    set_lw(5'd1, 5'd5);
    tick();
    check("lw_memread", 32'(ID_EX_MemRead), 32'd1);
    check("lw_rt", 32'(ID_EX_Rt), 32'd5);
    check("lw_aluop", 32'(ID_EX_ALUOp), 32'h2);
    check("lw_rd1", ID_EX_ReadData1, 32'hA000_0001);
    check("lw_signext", ID_EX_SignExt, 32'h0000_0010);

    // load-use on Rs
    set_add(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pcwrite", 32'(PCWrite), 32'd0);
    check("lu_ifid", 32'(IF_ID_Write), 32'd0);
    tick();
    check("lu_bub_valid", 32'(ID_EX_valid), 32'd0);
    check("lu_bub_memread", 32'(ID_EX_MemRead), 32'd0);
    check("lu_bub_regwrite", 32'(ID_EX_RegWrite), 32'd0);
    check("lu_bub_aluop", 32'(ID_EX_ALUOp), 32'd0);
    check("lu_count", 32'(bubble_count), 32'd1);
    check("lu_unstall", 32'(stall), 32'd0);
    check("lu_unstall_pc", 32'(PCWrite), 32'd1);
    tick();
    check("add_valid", 32'(ID_EX_valid), 32'd1);
    check("add_rd", 32'(ID_EX_Rd), 32'd7);
    check("add_regdst", 32'(ID_EX_RegDst), 32'd1);
    check("add_rd2", ID_EX_ReadData2, 32'hD000_0006);
    check("add_count", 32'(bubble_count), 32'd1);

    // Rt matches but Rt is not a source
    set_lw(5'd1, 5'd7);
    tick();
    set_add(5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    check("rtonly_stall", 32'(stall), 32'd0);
    tick();
    check("rtonly_valid", 32'(ID_EX_valid), 32'd1);
    check("rtonly_rs", 32'(ID_EX_Rs), 32'd3);

    // $0 destination never stalls
    set_lw(5'd2, 5'd0);
    tick();
    set_add(5'd0, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1);
    #1;
    check("zero_stall", 32'(stall), 32'd0);
    tick();

    // invalid ID instruction never stalls
    set_lw(5'd1, 5'd5);
    tick();
    set_add(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    check("inval_stall", 32'(stall), 32'd0);
    tick();
    check("inval_valid", 32'(ID_EX_valid), 32'd0);
    check("inval_count", 32'(bubble_count), 32'd1);

    // flush wins over load-use
    set_lw(5'd1, 5'd5);
    tick();
    set_add(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_pcwrite", 32'(PCWrite), 32'd1);
    check("flush_ifid", 32'(IF_ID_Write), 32'd1);
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(ID_EX_valid), 32'd0);
    check("flush_regwrite", 32'(ID_EX_RegWrite), 32'd0);
    check("flush_count", 32'(bubble_count), 32'd1);

    // load-use on Rt
    set_lw(5'd1, 5'd9);
    tick();
    set_add(5'd1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1);
    #1;
    check("rt_stall", 32'(stall), 32'd1);
    tick();
    check("rt_count", 32'(bubble_count), 32'd2);

    // async reset in the middle of a stall
    set_lw(5'd1, 5'd5);
    tick();
    set_add(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    #1;
    check("ar_pre_stall", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ID_EX_valid), 32'd0);
    check("ar_memread", 32'(ID_EX_MemRead), 32'd0);
    check("ar_rt", 32'(ID_EX_Rt), 32'd0);
    check("ar_rd1", ID_EX_ReadData1, 32'd0);
    check("ar_count", 32'(bubble_count), 32'd0);
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_pcwrite", 32'(PCWrite), 32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_after_valid", 32'(ID_EX_valid), 32'd1);
    check("ar_after_rd", 32'(ID_EX_Rd), 32'd7);

    // saturation: self-dependent lw keeps re-stalling every other cycle
    set_lw(5'd5, 5'd5);
    tick();
    #1;
    check("sat_stall", 32'(stall), 32'd1);
    force dut.bubble_count = 16'hFFFE;
    #1;
    release dut.bubble_count;
    tick();
    check("sat_ffff", 32'(bubble_count), 32'hFFFF);
    tick();
    #1;
    check("sat_stall2", 32'(stall), 32'd1);
    tick();
    check("sat_hold", 32'(bubble_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
